// File: rtl/function_dispatcher_pkg.sv
// Shared types and helpers for the function dispatcher: FSM states, fixed
// cycle counts and the lowest-set-bit priority encoder.
package function_dispatcher_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        CHECK = 3'd2,
        CLEAR = 3'd3,
        DRAIN = 3'd4
    } disp_state_t;

    localparam int DRAIN_CYCLES = 2;
    localparam int SYNC_STAGES  = 2;
    localparam int MAX_N        = 32;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic int unsigned lowest_set(input logic [MAX_N-1:0] v);
        lowest_set = 0;
        for (int i = MAX_N - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = $unsigned(i);
        end
    endfunction

endpackage

// File: rtl/function_dispatcher_sync.sv
// W-bit multi-flop synchronizer for the chooser's self-timed outputs,
// cleared by the synchronous active-high reset.
module sync_2ff
    import function_dispatcher_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage_q [SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/function_dispatcher.sv
// Clocked consumer of the asynchronous function chooser: serves each requested
// function over go/done in ascending order, then pulses chooser_rst and drains.
module function_dispatcher
    import function_dispatcher_pkg::*;
#(
    parameter int N          = 2,
    parameter int CLR_CYCLES = 2,
    parameter int TIMEOUT    = 1023,
    localparam int SW        = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  sets_in,
    input  logic          fin_in,
    output logic          chooser_rst,
    output logic [N-1:0]  go,
    input  logic [N-1:0]  done,
    output logic          busy,
    output logic [SW-1:0] sel,
    output logic          err_timeout,
    output logic          err_late
);

    localparam int CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int PMAX = (CLR_CYCLES > DRAIN_CYCLES) ? CLR_CYCLES : DRAIN_CYCLES;
    localparam int PW   = $clog2(PMAX + 1);

    localparam logic [CW-1:0] TLIM       = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [PW-1:0] CLR_LAST   = PW'(CLR_CYCLES - 1);
    localparam logic [PW-1:0] DRAIN_LAST = PW'(DRAIN_CYCLES - 1);

    logic [N-1:0]  sets_s;
    logic          fin_s;

    disp_state_t   state_q, state_d;
    logic [N-1:0]  pending_q, pending_d;
    logic [N-1:0]  served_q, served_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [N-1:0]  go_q, go_d;
    logic [SW-1:0] sel_q, sel_d;
    logic          crst_q, crst_d;
    logic          etout_q, etout_d;
    logic          elate_q, elate_d;

    logic [N-1:0]  fresh;
    logic [N-1:0]  merged;

    sync_2ff #(.W(N)) u_sync_sets (
        .clk (clk),
        .rst (rst),
        .d   (sets_in),
        .q   (sets_s)
    );

    sync_2ff #(.W(1)) u_sync_fin (
        .clk (clk),
        .rst (rst),
        .d   (fin_in),
        .q   (fin_s)
    );

    function automatic logic [SW-1:0] pick(input logic [N-1:0] v);
        pick = SW'(lowest_set(MAX_N'(v)));
    endfunction

    function automatic logic [N-1:0] onehot(input logic [SW-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    // Requests not yet served in this round; already-served bits stay masked
    // because the synchronizers lag the chooser clear by a couple of cycles.
    assign fresh  = sets_s & ~served_q;
    assign merged = pending_q | fresh;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        served_d  = served_q;
        cnt_d     = cnt_q;
        phase_d   = phase_q;
        go_d      = go_q;
        sel_d     = sel_q;
        crst_d    = 1'b0;
        etout_d   = etout_q;
        elate_d   = elate_q;

        case (state_q)
            IDLE: begin
                // fin without sets is synchronizer skew; wait for both.
                if (fin_s && sets_s != '0) begin
                    pending_d = sets_s;
                    sel_d     = pick(sets_s);
                    go_d      = onehot(pick(sets_s));
                    cnt_d     = '0;
                    state_d   = SERVE;
                end
            end
            SERVE: begin
                if (done[sel_q]) begin
                    pending_d[sel_q] = 1'b0;
                    served_d[sel_q]  = 1'b1;
                    go_d             = '0;
                    state_d          = CHECK;
                end else if (TIMEOUT != 0 && cnt_q == TLIM) begin
                    // Abandoned index still counts as served so it is not retried.
                    pending_d[sel_q] = 1'b0;
                    served_d[sel_q]  = 1'b1;
                    go_d             = '0;
                    etout_d          = 1'b1;
                    state_d          = CHECK;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CHECK: begin
                pending_d = merged;
                if (merged != '0) begin
                    sel_d   = pick(merged);
                    go_d    = onehot(pick(merged));
                    cnt_d   = '0;
                    state_d = SERVE;
                end else begin
                    crst_d  = 1'b1;
                    phase_d = '0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (fresh != '0) elate_d = 1'b1;
                if (phase_q == CLR_LAST) begin
                    phase_d = '0;
                    state_d = DRAIN;
                end else begin
                    phase_d = phase_q + 1'b1;
                    crst_d  = 1'b1;
                end
            end
            DRAIN: begin
                if (phase_q == DRAIN_LAST) begin
                    phase_d   = '0;
                    served_d  = '0;
                    pending_d = '0;
                    state_d   = IDLE;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            served_q  <= '0;
            cnt_q     <= '0;
            phase_q   <= '0;
            go_q      <= '0;
            sel_q     <= '0;
            crst_q    <= 1'b0;
            etout_q   <= 1'b0;
            elate_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            served_q  <= served_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            go_q      <= go_d;
            sel_q     <= sel_d;
            crst_q    <= crst_d;
            etout_q   <= etout_d;
            elate_q   <= elate_d;
        end
    end

    assign chooser_rst = crst_q;
    assign go          = go_q;
    assign sel         = sel_q;
    assign busy        = (state_q != IDLE);
    assign err_timeout = etout_q;
    assign err_late    = elate_q;

endmodule

// File: tb/tb_function_dispatcher.sv
// Bench for function_dispatcher: chooser and function-unit models, a grant
// scoreboard fed from the stimulus, and pulse-length monitors.
module tb_function_dispatcher;

    localparam int N   = 4;
    localparam int CLR = 3;
    localparam int TMO = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] sets_in;
    logic         fin_in;
    logic         chooser_rst;
    logic [N-1:0] go;
    logic [N-1:0] done;
    logic         busy;
    logic [1:0]   sel;
    logic         err_timeout;
    logic         err_late;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [N-1:0] exp_q[$];
    int           dly[N];
    int           gcnt[N];
    int           clr_pulses;
    int           last_glen;
    logic         crst_seen;

    always #5 clk = ~clk;

    function_dispatcher #(
        .N          (N),
        .CLR_CYCLES (CLR),
        .TIMEOUT    (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sets_in     (sets_in),
        .fin_in      (fin_in),
        .chooser_rst (chooser_rst),
        .go          (go),
        .done        (done),
        .busy        (busy),
        .sel         (sel),
        .err_timeout (err_timeout),
        .err_late    (err_late)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int idx_of(input logic [N-1:0] v);
        idx_of = 0;
        for (int i = N - 1; i >= 0; i--) if (v[i]) idx_of = i;
    endfunction

    // One cycle step; the chooser model drops its latches on a chooser_rst rise.
    task automatic step();
        @(negedge clk);
        if (chooser_rst && !crst_seen) begin
            sets_in = '0;
            fin_in  = 1'b0;
        end
        crst_seen = chooser_rst;
    endtask

    task automatic wait_round();
        int t;
        t = 0;
        while (!busy && t < 50) begin step(); t++; end
        check("round_start", busy, 1);
        t = 0;
        while (busy && t < 200) begin step(); t++; end
        check("round_end", busy, 0);
    endtask

    // Function units: raise done for one cycle dly[i] cycles after go[i]; 0 = never.
    initial begin
        done = '0;
        for (int i = 0; i < N; i++) begin
            gcnt[i] = 0;
            dly[i]  = 2;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (go[i]) begin
                    gcnt[i]++;
                    done[i] = (dly[i] != 0 && gcnt[i] == dly[i]);
                end else begin
                    gcnt[i] = 0;
                    done[i] = 1'b0;
                end
            end
        end
    end

    // Grant scoreboard plus go / chooser_rst / drain length monitors.
    initial begin
        logic [N-1:0] go_prev;
        logic [N-1:0] e;
        logic         crst_prev;
        int           glen, clen, dcnt;
        bit           dtrack;
        go_prev = '0; crst_prev = 1'b0; glen = 0; clen = 0; dcnt = 0; dtrack = 0;
        forever begin
            @(negedge clk);
            if (go != '0 && go != go_prev) begin
                if (exp_q.size() == 0) begin
                    check("grant_unexpected", go, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("grant", go, e);
                    check("sel", sel, idx_of(e));
                end
            end
            if (go != '0) glen++;
            else if (go_prev != '0) begin
                last_glen = glen;
                glen      = 0;
            end
            if (chooser_rst) begin
                clen++;
            end else if (crst_prev) begin
                check("clr_len", clen, CLR);
                clr_pulses++;
                clen   = 0;
                dtrack = 1;
                dcnt   = 0;
            end else if (dtrack) begin
                dcnt++;
                if (!busy || dcnt > 8) begin
                    check("drain_len", dcnt, 2);
                    dtrack = 0;
                end
            end
            go_prev   = go;
            crst_prev = chooser_rst;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, t;
        rst = 1'b1; sets_in = '0; fin_in = 1'b0;
        clr_pulses = 0; last_glen = 0; crst_seen = 1'b0;
        repeat (3) step();
        check("rst_go", go, 0);
        check("rst_chooser_rst", chooser_rst, 0);
        check("rst_busy", busy, 0);
        check("rst_sel", sel, 0);
        check("rst_err_timeout", err_timeout, 0);
        check("rst_err_late", err_late, 0);
        rst = 1'b0;
        repeat (2) step();

        // Single function, latency from request to go.
        clr_pulses = 0;
        exp_q.push_back(4'b0001);
        sets_in = 4'b0001; fin_in = 1'b1;
        lat = 0;
        while (go == '0 && lat < 6) begin @(posedge clk); #1; lat++; end
        check("latency", lat, 3);
        wait_round();
        check("t1_pulses", clr_pulses, 1);
        check("t1_err_timeout", err_timeout, 0);
        repeat (2) step();

        // Two functions served in ascending order, one clear pulse.
        clr_pulses = 0;
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b1000);
        sets_in = 4'b1010; fin_in = 1'b1;
        wait_round();
        check("t2_pulses", clr_pulses, 1);
        repeat (2) step();

        // Lower index arriving while go[2] is high is served at the next CHECK.
        clr_pulses = 0;
        dly[2] = 4;
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b0001);
        sets_in = 4'b0100; fin_in = 1'b1;
        t = 0;
        while (!go[2] && t < 20) begin step(); t++; end
        check("t3_go2", go[2], 1);
        sets_in[0] = 1'b1;
        wait_round();
        check("t3_pulses", clr_pulses, 1);
        check("t3_err_late", err_late, 0);
        dly[2] = 2;
        repeat (2) step();

        // Unit never answers: abandoned after TMO cycles of go.
        clr_pulses = 0;
        dly[1] = 0;
        exp_q.push_back(4'b0010);
        sets_in = 4'b0010; fin_in = 1'b1;
        wait_round();
        check("t4_go_len", last_glen, TMO);
        check("t4_err_timeout", err_timeout, 1);
        check("t4_pulses", clr_pulses, 1);
        check("t4_err_late", err_late, 0);
        dly[1] = 2;
        repeat (2) step();

        // Request appearing during CLEAR is flagged, then served in a new round.
        clr_pulses = 0;
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b1000);
        sets_in = 4'b0001; fin_in = 1'b1;
        t = 0;
        while (!chooser_rst && t < 40) begin step(); t++; end
        check("t5_clr_seen", chooser_rst, 1);
        sets_in[3] = 1'b1; fin_in = 1'b1;
        wait_round();
        check("t5_err_late", err_late, 1);
        wait_round();
        check("t5_pulses", clr_pulses, 2);
        check("t5_err_timeout_sticky", err_timeout, 1);
        repeat (2) step();

        // Reset in the middle of SERVE abandons the function with no clear pulse.
        clr_pulses = 0;
        dly[0] = 0;
        exp_q.push_back(4'b0001);
        sets_in = 4'b0001; fin_in = 1'b1;
        t = 0;
        while (!go[0] && t < 20) begin step(); t++; end
        check("t6_go0", go[0], 1);
        repeat (2) step();
        rst = 1'b1;
        @(posedge clk); #1;
        check("t6_go", go, 0);
        check("t6_busy", busy, 0);
        check("t6_chooser_rst", chooser_rst, 0);
        check("t6_sel", sel, 0);
        check("t6_err_timeout", err_timeout, 0);
        check("t6_err_late", err_late, 0);
        step();
        rst = 1'b0; sets_in = '0; fin_in = 1'b0; dly[0] = 2;
        repeat (6) step();
        check("t6_idle_busy", busy, 0);
        check("t6_pulses", clr_pulses, 0);
        check("exp_q_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/function_dispatcher.md
# function_dispatcher

Synchronous consumer for the asynchronous function-chooser stage. Samples the chooser's latched `sets` vector and `fin` flag into the `clk` domain. Dispatches each selected function to its function unit in turn over a go/done handshake, then pulses the chooser's `rst` input to clear its latches. Sits directly downstream of the chooser and is the boundary between the self-timed request front end and the clocked function units.

## Interface
- `N`, 2: number of functions; width of `sets_in`, `go`, `done`.
- `CLR_CYCLES`, 2: cycles `chooser_rst` is held high; must be ≥1.
- `TIMEOUT`, 1023: max cycles waiting for `done` per function; 0 disables the timeout.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `sets_in`, in, N: chooser `sets`; asynchronous to `clk`.
- `fin_in`, in, 1: chooser `fin`; asynchronous to `clk`.
- `chooser_rst`, out, 1: drives chooser `rst`; a rising edge clears all chooser latches.
- `go`, out, N: one-hot start request to function unit i.
- `done`, in, N: completion from function unit i; synchronous to `clk`.
- `busy`, out, 1: high in every state except IDLE.
- `sel`, out, max(1,$clog2(N)): index currently served; valid while any `go` bit is high.
- `err_timeout`, out, 1: sticky; a function was abandoned on timeout.
- `err_late`, out, 1: sticky; request bits appeared during CLEAR and may have been lost.

## Operation
- `sets_in` and `fin_in` each pass through a 2-flop synchronizer, producing `sets_s` and `fin_s`.
- State machine: IDLE, SERVE, CHECK, CLEAR, DRAIN.
- **IDLE**
  - If `fin_s`=1 and `sets_s`≠0: `pending` ← `sets_s`, go to SERVE.
  - `fin_s`=1 with `sets_s`=0 (synchronizer skew) is ignored; remain in IDLE.
- **SERVE**
  - `sel` = lowest set index in `pending`; `go[sel]`=1, all other `go` bits 0.
  - When `done[sel]`=1 is sampled: clear `pending[sel]`, drop `go`, go to CHECK.
  - `done` bits other than `done[sel]` are ignored.
  - Timeout: if `TIMEOUT`≠0 and the wait counter reaches `TIMEOUT` without `done[sel]`, set `err_timeout`, clear `pending[sel]`, go to CHECK.
- **CHECK** (one cycle)
  - `pending` ← `pending` | (`sets_s` & ~`served`), where `served` accumulates the indices completed since IDLE.
  - If the result is nonzero, go to SERVE; otherwise go to CLEAR.
- **CLEAR**
  - `chooser_rst`=1 for exactly `CLR_CYCLES` cycles.
  - Any `sets_s` bit not in `served`, sampled during CLEAR, sets `err_late`.
  - Then go to DRAIN.
- **DRAIN**
  - Exactly 2 cycles, `chooser_rst`=0, so the synchronizers flush stale values.
  - Clear `served`, go to IDLE.
- Each index is served at most once per IDLE-to-IDLE round.
- Order within a round is ascending index, except that newly arrived lower indices are served at the next CHECK.
- **Reset** (`rst`=1 at a clock edge, any state)
  - State ← IDLE.
  - `go`=0, `chooser_rst`=0, `busy`=0, `sel`=0, `err_timeout`=0, `err_late`=0.
  - `pending`=0, `served`=0, counter=0, synchronizer flops=0.
  - A function in flight is abandoned; no `chooser_rst` pulse is issued.

## Timing
- `sets_in` rising just before edge 0: `sets_s` valid after edge 1, IDLE→SERVE at edge 2, `go` high after edge 2. Latency is 3 edges worst case.
- `go` is registered.
- `done[sel]` sampled high at edge k: `go` low after edge k, CHECK during cycle k+1, next `go` or CLEAR after edge k+1.
- `go` is never reasserted for the same index in a round; a unit that holds `done` high is not an error.
- Wait counter:
  - resets on SERVE entry;
  - width `$clog2(TIMEOUT+1)`;
  - saturates; no wrap-around.
- Minimum round for one function with immediate `done`: SERVE(1) + CHECK(1) + CLEAR(`CLR_CYCLES`) + DRAIN(2) cycles.
- `chooser_rst` is glitch-free: a direct register output, high only in CLEAR.

## Structure
- Shared package `function_dispatcher_pkg`:
  - state enum `disp_state_t`;
  - `DRAIN_CYCLES`=2;
  - `SYNC_STAGES`=2.
- Sub-module `sync_2ff #(W)`: W-bit 2-flop synchronizer with synchronous active-high reset; instantiated twice (`sets_in`, `fin_in`).
- Lowest-set-bit priority encoder is a function in the package.

## Test plan
- N=2, `sets_in`=01, `fin_in`=1; `done[0]` pulses 2 cycles after `go[0]` → `go`=01 after ≤3 edges, `sel`=0, one `chooser_rst` pulse of 2 cycles, `busy` low 2 cycles later.
- N=4, `sets_in`=1010 → `go`=0010 then 1000, strictly sequential, single `chooser_rst` pulse after both complete.
- N=4, `sets_in`=0100; bit 0 rises while `go[2]` is high → `go[0]` served at next CHECK, `err_late`=0.
- `TIMEOUT`=8, `done` held 0 → `go` high exactly 8 cycles, `err_timeout`=1, CLEAR still issued, error sticky until `rst`.
- New bit rises only during CLEAR → `err_late`=1; after DRAIN, if the chooser still holds it, a fresh round serves it.
- `rst` asserted mid-SERVE → next cycle `go`=0, `busy`=0, `chooser_rst`=0, all flags 0.
